// File: rtl/prco_seq_ctrl_if.sv
// Handshake bundle between the prco sequencer and the pipeline/fetch/debug logic around it.
// Breakpoint signals exist only when PRCO_SEQ_BREAKPOINT_EN is defined.
interface prco_seq_ctrl_if #(
  parameter int PC_W = 16
`ifdef PRCO_SEQ_BREAKPOINT_EN
  ,
  parameter int NUM_BP = 2
`endif
);
  logic            i_mode;
  logic            i_step;
  logic            i_halt;
  logic            i_done;
  logic            i_branch;
  logic [PC_W-1:0] i_branch_tgt;
  logic            q_ce;
  logic [PC_W-1:0] q_pc;
  logic [1:0]      q_state;
  logic            q_debug_instr_clk;
  logic [31:0]     q_icount;
`ifdef PRCO_SEQ_BREAKPOINT_EN
  logic [NUM_BP*PC_W-1:0] i_bp_addr;
  logic [NUM_BP-1:0]      i_bp_en;
  logic                   q_bp_hit;
`endif

  // Core/debug side: drives requests, observes the sequencer.
  modport master (
    output i_mode, i_step, i_halt, i_done, i_branch, i_branch_tgt,
`ifdef PRCO_SEQ_BREAKPOINT_EN
    output i_bp_addr, i_bp_en,
    input  q_bp_hit,
`endif
    input  q_ce, q_pc, q_state, q_debug_instr_clk, q_icount
  );

  // Sequencer side.
  modport slave (
    input  i_mode, i_step, i_halt, i_done, i_branch, i_branch_tgt,
`ifdef PRCO_SEQ_BREAKPOINT_EN
    input  i_bp_addr, i_bp_en,
    output q_bp_hit,
`endif
    output q_ce, q_pc, q_state, q_debug_instr_clk, q_icount
  );
endinterface

// File: rtl/prco_seq_ctrl.sv
// Instruction sequencer for the prco CPU: PC ownership, issue/retire handshake, halt, single-step, retire count.
// Optional breakpoint comparators are compiled in with PRCO_SEQ_BREAKPOINT_EN.
module prco_seq_ctrl #(
  parameter int PC_W      = 16,
  parameter int RESET_VEC = 0,
  parameter int PC_INC    = 1,
  parameter int NUM_BP    = 2
) (
  input logic           i_clk,
  input logic           i_reset,
  prco_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_STEP  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [PC_W-1:0] PC_RESET = PC_W'(RESET_VEC);
  localparam logic [PC_W-1:0] PC_STEP  = PC_W'(PC_INC);
  localparam int              BP_CNT   = (NUM_BP > 0) ? NUM_BP : 1;

  state_t          state_reg;
  logic [PC_W-1:0] pc_reg;
  logic [PC_W-1:0] tgt_reg;
  logic            pending_reg;
  logic [31:0]     icount_reg;
  logic            dbg_reg;
  logic            ce_reg;
  logic            bp_hit_reg;
  logic            step_prev_reg;
  logic            mode_prev_reg;

  logic [PC_W-1:0]   next_pc;
  logic [BP_CNT-1:0] bp_match;
  logic              bp_hit;
  logic              step_edge;
  logic              mode_fall;

  // A branch in the retire cycle beats an earlier captured one.
  assign next_pc   = bus.i_branch ? bus.i_branch_tgt :
                     pending_reg  ? tgt_reg : pc_reg + PC_STEP;
  assign step_edge = bus.i_step & ~step_prev_reg;
  assign mode_fall = ~bus.i_mode & mode_prev_reg;

`ifdef PRCO_SEQ_BREAKPOINT_EN
  for (genvar gi = 0; gi < BP_CNT; gi++) begin : g_bp
    if (gi < NUM_BP) begin : g_cmp
      assign bp_match[gi] = bus.i_bp_en[gi] &&
                            (next_pc == bus.i_bp_addr[gi*PC_W +: PC_W]);
    end else begin : g_pad
      assign bp_match[gi] = 1'b0;
    end
  end
  assign bus.q_bp_hit = bp_hit_reg;
`else
  assign bp_match = '0;
`endif
  assign bp_hit = |bp_match;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg     <= ST_ISSUE;
      pc_reg        <= PC_RESET;
      tgt_reg       <= '0;
      pending_reg   <= 1'b0;
      icount_reg    <= '0;
      dbg_reg       <= 1'b0;
      ce_reg        <= 1'b1;
      bp_hit_reg    <= 1'b0;
      step_prev_reg <= 1'b0;
      mode_prev_reg <= 1'b0;
    end else begin
      // Edge trackers run in every state so edges outside STEP are dropped, not queued.
      step_prev_reg <= bus.i_step;
      mode_prev_reg <= bus.i_mode;
      dbg_reg       <= 1'b0;
      bp_hit_reg    <= 1'b0;
      ce_reg        <= 1'b0;
      case (state_reg)
        ST_ISSUE: begin
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.i_done) begin
            pc_reg      <= next_pc;
            pending_reg <= 1'b0;
            icount_reg  <= icount_reg + 32'd1;
            dbg_reg     <= 1'b1;
            if (bus.i_halt) begin
              state_reg <= ST_HALT;
            end else if (bp_hit) begin
              state_reg  <= ST_STEP;
              bp_hit_reg <= 1'b1;
            end else if (bus.i_mode) begin
              state_reg <= ST_STEP;
            end else begin
              state_reg <= ST_ISSUE;
              ce_reg    <= 1'b1;
            end
          end else if (bus.i_branch) begin
            pending_reg <= 1'b1;
            tgt_reg     <= bus.i_branch_tgt;
          end
        end
        ST_STEP: begin
          if (bus.i_halt) begin
            state_reg <= ST_HALT;
          end else if (step_edge || mode_fall) begin
            state_reg <= ST_ISSUE;
            ce_reg    <= 1'b1;
          end
        end
        ST_HALT: begin
          if (!bus.i_halt) begin
            if (bus.i_mode) begin
              state_reg <= ST_STEP;
            end else begin
              state_reg <= ST_ISSUE;
              ce_reg    <= 1'b1;
            end
          end
        end
        default: state_reg <= ST_ISSUE;
      endcase
    end
  end

  assign bus.q_ce              = ce_reg;
  assign bus.q_pc              = pc_reg;
  assign bus.q_state           = state_reg;
  assign bus.q_debug_instr_clk = dbg_reg;
  assign bus.q_icount          = icount_reg;
endmodule
